// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
package imem_loader_pkg;

  localparam int DEPTH_DEFAULT = 1024;

  typedef logic [15:0] len_t;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHK
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, word writes out; master is the loader side.
interface imem_loader_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Assembles four little-endian bytes into a word; word_valid_o pulses the
// cycle after the fourth byte, with word_o holding that word.
module word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sh_q, sh_d;
  logic        vld_q, vld_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    vld_d  = 1'b0;
    word_d = word_q;
    if (clear_i) begin
      cnt_d = 2'd0;
    end else if (byte_valid_i) begin
      // Newest byte enters at the top so the first byte ends up in [7:0].
      sh_d  = {byte_i, sh_q[23:8]};
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        vld_d  = 1'b1;
        word_d = {byte_i, sh_q};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= 2'd0;
      sh_q   <= 24'd0;
      vld_q  <= 1'b0;
      word_q <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      vld_q  <= vld_d;
      word_q <= word_d;
    end
  end

  assign word_valid_o = vld_q;
  assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed program into instruction memory
// while holding the core off fetch.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state_q, state_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [17:0] bytes_left_q, bytes_left_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  chk_q, chk_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        busy_w;
  logic        acc;
  len_t        len_n;
  logic        pk_clear;
  logic        pk_valid;
  logic        pk_word_valid;
  logic [31:0] pk_word;

  assign busy_w   = (state_q != IDLE);
  // Abort outranks a simultaneous handshake: the byte is dropped.
  assign acc      = bus.rx_valid && busy_w && !abort;
  assign len_n    = {bus.rx_data, len_lo_q};
  assign pk_valid = acc && (state_q == DATA);
  assign pk_clear = (state_q != DATA) || abort;

  word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (pk_clear),
    .byte_valid_i (pk_valid),
    .byte_i       (bus.rx_data),
    .word_valid_o (pk_word_valid),
    .word_o       (pk_word)
  );

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    bytes_left_d = bytes_left_q;
    addr_d       = addr_q;
    chk_d        = chk_q;
    done_d       = done_q;
    error_d      = error_q;

    if (pk_word_valid) begin
      addr_d = addr_q + 32'd4;
    end

    if (state_q == IDLE) begin
      if (start) begin
        state_d = LEN_LO;
        done_d  = 1'b0;
        error_d = 1'b0;
        addr_d  = 32'd0;
        chk_d   = 8'd0;
      end
    end else if (abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
      error_d = 1'b1;
    end else if (acc) begin
      case (state_q)
        LEN_LO: begin
          len_lo_d = bus.rx_data;
          state_d  = LEN_HI;
        end
        LEN_HI: begin
          if (len_n == 16'd0) begin
            state_d = CHK;
          end else if ({1'b0, len_n} > DEPTH_W) begin
            state_d = IDLE;
            error_d = 1'b1;
          end else begin
            state_d      = DATA;
            bytes_left_d = {len_n, 2'b00};
          end
        end
        DATA: begin
          chk_d        = chk_q ^ bus.rx_data;
          bytes_left_d = bytes_left_q - 18'd1;
          if (bytes_left_q == 18'd1) begin
            state_d = CHK;
          end
        end
        CHK: begin
          state_d = IDLE;
          if (bus.rx_data == chk_q) begin
            done_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      len_lo_q     <= 8'd0;
      bytes_left_q <= 18'd0;
      addr_q       <= 32'd0;
      chk_q        <= 8'd0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      bytes_left_q <= bytes_left_d;
      addr_q       <= addr_d;
      chk_q        <= chk_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.rx_ready  = busy_w;
  assign bus.mem_we    = pk_word_valid;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = pk_word;
  assign busy          = busy_w;
  // An aborted load may still be finishing its last write.
  assign cpu_hold      = busy_w || pk_word_valid;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good load, bad checksum, oversize length,
// empty program, aborts and mid-load reset.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic cpu_hold, busy, done, error;

  imem_loader_if bus();

  imem_loader #(.DEPTH(1024)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .bus      (bus.master),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_cnt = wr_cnt + 1;
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [7:0] good_chk;

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    // XOR of the eight data bytes of the two-word program.
    good_chk = 8'h13 ^ 8'h04 ^ 8'hC3 ^ 8'h00 ^ 8'h67 ^ 8'h02 ^ 8'h80 ^ 8'h00;

    repeat (2) tick();
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b0;
    tick();

    // Good two-word load.
    pulse_start();
    check("a_busy", 32'(busy), 32'd1);
    check("a_rx_ready", 32'(bus.rx_ready), 32'd1);
    check("a_hold", 32'(cpu_hold), 32'd1);
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h04); send(8'hC3); send(8'h00);
    send(8'h67); send(8'h02); send(8'h80); send(8'h00);
    check("a_we_last", 32'(bus.mem_we), 32'd1);
    check("a_addr_last", bus.mem_addr, 32'h4);
    check("a_wdata_last", bus.mem_wdata, 32'h0080_0267);
    check("a_hold_last", 32'(cpu_hold), 32'd1);
    send(good_chk);
    check("a_done", 32'(done), 32'd1);
    check("a_error", 32'(error), 32'd0);
    check("a_busy_end", 32'(busy), 32'd0);
    check("a_hold_end", 32'(cpu_hold), 32'd0);
    check("a_we_end", 32'(bus.mem_we), 32'd0);
    check("a_addr_end", bus.mem_addr, 32'h8);
    check("a_wr_cnt", 32'(wr_cnt), 32'd2);
    check("a_wr0_addr", wr_addr[0], 32'h0);
    check("a_wr0_data", wr_data[0], 32'h00C3_0413);
    check("a_wr1_addr", wr_addr[1], 32'h4);
    check("a_wr1_data", wr_data[1], 32'h0080_0267);

    // Abort while idle changes nothing.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_done", 32'(done), 32'd1);
    check("idle_abort_error", 32'(error), 32'd0);
    check("idle_abort_busy", 32'(busy), 32'd0);

    // Same program, wrong checksum.
    pulse_start();
    check("b_done_cleared", 32'(done), 32'd0);
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h04); send(8'hC3); send(8'h00);
    send(8'h67); send(8'h02); send(8'h80); send(8'h00);
    send(8'h00);
    check("b_error", 32'(error), 32'd1);
    check("b_done", 32'(done), 32'd0);
    check("b_wr_cnt", 32'(wr_cnt), 32'd4);

    // Length 1025 exceeds the 1024-word memory.
    pulse_start();
    check("c_error_cleared", 32'(error), 32'd0);
    send(8'h01); send(8'h04);
    check("c_error", 32'(error), 32'd1);
    check("c_done", 32'(done), 32'd0);
    check("c_busy", 32'(busy), 32'd0);
    check("c_rx_ready", 32'(bus.rx_ready), 32'd0);
    repeat (3) tick();
    check("c_wr_cnt", 32'(wr_cnt), 32'd4);

    // Empty program goes straight to the checksum byte.
    pulse_start();
    send(8'h00); send(8'h00);
    check("d_busy_chk", 32'(busy), 32'd1);
    send(8'h00);
    check("d_done", 32'(done), 32'd1);
    check("d_error", 32'(error), 32'd0);
    check("d_wr_cnt", 32'(wr_cnt), 32'd4);

    // Abort on the third byte of word 1: only word 0 lands.
    pulse_start();
    send(8'h02); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66);
    bus.rx_data  = 8'h77;
    bus.rx_valid = 1'b1;
    abort        = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    abort        = 1'b0;
    check("e_error", 32'(error), 32'd1);
    check("e_done", 32'(done), 32'd0);
    check("e_busy", 32'(busy), 32'd0);
    send(8'h88);
    repeat (3) tick();
    check("e_wr_cnt", 32'(wr_cnt), 32'd5);
    check("e_wr_addr", wr_addr[4], 32'h0);
    check("e_wr_data", wr_data[4], 32'h4433_2211);

    // Abort during the final write still lets that write complete.
    pulse_start();
    send(8'h01); send(8'h00);
    send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
    check("f_we", 32'(bus.mem_we), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("f_error", 32'(error), 32'd1);
    check("f_busy", 32'(busy), 32'd0);
    check("f_hold", 32'(cpu_hold), 32'd0);
    check("f_wr_cnt", 32'(wr_cnt), 32'd6);
    check("f_wr_data", wr_data[5], 32'hD4C3_B2A1);

    // Reset mid-DATA, then a fresh load starting again at address 0.
    pulse_start();
    send(8'h03); send(8'h00);
    send(8'h01); send(8'h02);
    reset = 1'b1;
    #1;
    check("g_rst_busy", 32'(busy), 32'd0);
    check("g_rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("g_rst_hold", 32'(cpu_hold), 32'd0);
    check("g_rst_error", 32'(error), 32'd0);
    check("g_rst_done", 32'(done), 32'd0);
    check("g_rst_addr", bus.mem_addr, 32'd0);
    check("g_rst_wdata", bus.mem_wdata, 32'd0);
    check("g_rst_we", 32'(bus.mem_we), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    pulse_start();
    send(8'h01);
    start = 1'b1;
    send(8'h00);
    start = 1'b0;
    check("g_busy_start_ignored", 32'(busy), 32'd1);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    check("g_we", 32'(bus.mem_we), 32'd1);
    check("g_addr", bus.mem_addr, 32'h0);
    check("g_wdata", bus.mem_wdata, 32'hDDCC_BBAA);
    send(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD);
    check("g_done", 32'(done), 32'd1);
    check("g_error", 32'(error), 32'd0);
    check("g_wr_cnt", 32'(wr_cnt), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
